// File: rtl/tw_pkg.sv
// tw_pkg: shared widths, ROM write codes and FSM states for the twiddle horizontal-load port
package tw_pkg;
    localparam int P_WIDTH     = 128;
    localparam int DW          = P_WIDTH / 2;
    localparam int NUM_ENTRIES = 4;
    localparam int IDX_W       = $clog2(NUM_ENTRIES);
    localparam int GAP_CYCLES  = 1;
    localparam int GAP_W       = $clog2(GAP_CYCLES) + 1;
    localparam logic [1:0] ROM_W_IDLE = 2'd0;
    localparam logic [1:0] ROM_W_HI   = 2'd1;
    localparam logic [1:0] ROM_W_LO   = 2'd2;
    typedef enum logic [2:0] {FILL, WAIT, SEND_HI, SEND_LO, GAP} tx_state_e;
endpackage

// File: rtl/tw_word_buf.sv
// tw_word_buf: NUM_ENTRIES x P_WIDTH register file, one write port, one comb half-select read port
module tw_word_buf
    import tw_pkg::*;
(
    input  logic               CLK,
    input  logic               we,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [P_WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0]   rd_idx,
    input  logic               rd_hi,
    output logic [DW-1:0]      rd_half
);
    logic [P_WIDTH-1:0] mem_q [NUM_ENTRIES];

    always_ff @(posedge CLK)
        if (we) mem_q[wr_idx] <= wr_data;

    assign rd_half = rd_hi ? mem_q[rd_idx][P_WIDTH-1:DW] : mem_q[rd_idx][DW-1:0];
endmodule

// File: rtl/tw_horizontal_tx.sv
// tw_horizontal_tx: buffers NUM_ENTRIES twiddle words, then replays high halves then low halves into the ROM
module tw_horizontal_tx
    import tw_pkg::*;
(
    input  logic               CLK,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               tx_en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [P_WIDTH-1:0] in_data,
    output logic [DW-1:0]      tf_out,
    output logic [1:0]         rom_w,
    output logic               busy,
    output logic               done
);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    tx_state_e        state_q, state_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [DW-1:0]    tf_out_d, rd_half;
    logic [1:0]       rom_w_d;
    logic             busy_d, done_d, we;

    assign in_ready = state_q == FILL;
    assign we       = in_valid && in_ready && !flush;

    tw_word_buf u_buf (
        .CLK     (CLK),
        .we      (we),
        .wr_idx  (wr_idx_q),
        .wr_data (in_data),
        .rd_idx  (rd_idx_d),
        .rd_hi   (state_d == SEND_HI),
        .rd_half (rd_half)
    );

    // Outputs are decoded from the next state so they register in lockstep with it.
    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        gap_cnt_d = gap_cnt_q;
        if (flush) begin
            state_d   = FILL;
            wr_idx_d  = '0;
            rd_idx_d  = '0;
            gap_cnt_d = '0;
        end else begin
            case (state_q)
                FILL: if (we) begin
                    wr_idx_d = wr_idx_q + 1'b1;
                    if (wr_idx_q == IDX_LAST) begin
                        state_d  = WAIT;
                        wr_idx_d = '0;
                    end
                end
                WAIT: if (tx_en) begin
                    state_d  = SEND_HI;
                    rd_idx_d = '0;
                end
                SEND_HI, SEND_LO: begin
                    rd_idx_d = rd_idx_q + 1'b1;
                    if (rd_idx_q == IDX_LAST) begin
                        rd_idx_d  = '0;
                        gap_cnt_d = '0;
                        if (state_q == SEND_HI) state_d = SEND_LO;
                        else state_d = GAP;
                    end
                end
                GAP: begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d   = FILL;
                        gap_cnt_d = '0;
                    end
                end
                default: state_d = FILL;
            endcase
        end
        rom_w_d  = state_d == SEND_HI ? ROM_W_HI : state_d == SEND_LO ? ROM_W_LO : ROM_W_IDLE;
        tf_out_d = rom_w_d == ROM_W_IDLE ? '0 : rd_half;
        busy_d   = state_d inside {SEND_HI, SEND_LO, GAP};
        done_d   = state_d == GAP && gap_cnt_d == GAP_LAST;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            gap_cnt_q <= '0;
            tf_out    <= '0;
            rom_w     <= ROM_W_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            gap_cnt_q <= gap_cnt_d;
            tf_out    <= tf_out_d;
            rom_w     <= rom_w_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end
endmodule

// File: tb/tb_tw_horizontal_tx.sv
// tb_tw_horizontal_tx: directed checks of load, replay, backpressure, flush and async reset
module tb_tw_horizontal_tx;
    logic         CLK = 1'b0, rst_n = 1'b0, flush = 1'b0, tx_en = 1'b0, in_valid = 1'b0;
    logic [127:0] in_data = '0;
    logic         in_ready, busy, done;
    logic [63:0]  tf_out;
    logic [1:0]   rom_w;
    int           total = 0, bad = 0, base = 0, k = 0;
    logic         acc;
    logic [127:0] wa [8];

    always #5 CLK = ~CLK;

    tw_horizontal_tx dut (
        .CLK      (CLK),
        .rst_n    (rst_n),
        .flush    (flush),
        .tx_en    (tx_en),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .tf_out   (tf_out),
        .rom_w    (rom_w),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input int b);
        base = b;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = wa[b+i];
            step();
        end
        in_valid = 1'b0;
        chk("wait_in_ready", in_ready, 0);
    endtask

    task automatic burst(input logic keep_en);
        tx_en = 1'b1;
        step();
        if (!keep_en) tx_en = 1'b0;
        for (int c = 0; c < 8; c++) begin
            chk("burst_rom_w", rom_w, c < 4 ? 1 : 2);
            chk("burst_tf_out", tf_out, c < 4 ? wa[base+c][127:64] : wa[base+c-4][63:0]);
            chk("burst_busy", busy, 1);
            chk("burst_in_ready", in_ready, 0);
            step();
        end
        chk("gap_rom_w", rom_w, 0);
        chk("gap_tf_out", tf_out, 0);
        chk("gap_done", done, 1);
        chk("gap_busy", busy, 1);
        step();
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("post_in_ready", in_ready, 1);
    endtask

    always @(negedge CLK) begin
        total++;
        assert (rom_w != 2'd3 && (rom_w != 2'd0 || tf_out == 64'd0)) else begin
            bad++;
            $error("FAIL idle_code rom_w=%0d tf_out=%h expected code<3 and tf_out=0 when idle", rom_w, tf_out);
        end
    end

    initial begin
        wa[0] = 128'h0123456789abcdef_fedcba9876543210;
        wa[1] = 128'h0400000000000400_840fa37ec53a39e1;
        wa[2] = 128'h1111111111111111_2222222222222222;
        wa[3] = 128'h3333333333333333_4444444444444444;
        wa[4] = 128'h5555555555555555_6666666666666666;
        wa[5] = 128'h7777777777777777_8888888888888888;
        wa[6] = 128'h9999999999999999_aaaaaaaaaaaaaaaa;
        wa[7] = 128'hbbbbbbbbbbbbbbbb_cccccccccccccccc;
        #12;
        chk("rst_rom_w", rom_w, 0);
        chk("rst_tf_out", tf_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        step();

        load(0);
        burst(1'b0);
        chk("w1_hi_const", wa[1][127:64], 64'h0400000000000400);

        in_valid = 1'b1;
        in_data  = wa[0];
        k = 0;
        for (int i = 0; i < 4; i++) begin
            acc = in_ready;
            step();
            if (acc) k++;
            in_data = wa[k];
        end
        chk("bp_accepted", k, 4);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("bp_in_ready", in_ready, 0);
            chk("wait_rom_w", rom_w, 0);
            chk("wait_busy", busy, 0);
        end
        base = 0;
        burst(1'b0);
        load(4);
        burst(1'b0);

        load(0);
        tx_en = 1'b1;
        step();
        tx_en = 1'b0;
        repeat (6) step();
        chk("pre_flush_rom_w", rom_w, 2);
        chk("pre_flush_tf_out", tf_out, wa[2][63:0]);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_rom_w", rom_w, 0);
        chk("flush_busy", busy, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_tf_out", tf_out, 0);
        chk("flush_done", done, 0);
        load(4);
        burst(1'b0);

        tx_en = 1'b1;
        load(0);
        burst(1'b1);
        load(4);
        burst(1'b1);
        tx_en = 1'b0;

        load(0);
        tx_en = 1'b1;
        step();
        tx_en = 1'b0;
        step();
        chk("mid_hi_rom_w", rom_w, 1);
        chk("mid_hi_tf_out", tf_out, wa[1][127:64]);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rom_w", rom_w, 0);
        chk("arst_tf_out", tf_out, 0);
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 1);
        #3 rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_rom_w", rom_w, 0);
        load(4);
        burst(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
